riscv_mdu: RTL
==============

// Module: riscv_mdu
// PURPOSE
//   Iterative RV32M multiply/divide unit in the execute stage, alongside the ALU.
//   It takes the same rs1/rs2 operands from decode and a funct3-coded op.
//   The writeback mux selects its result over the ALU result when valid_o is high.
//   Decode holds the pipeline stalled while busy_o is high.
// PARAMETERS
//   DATA_W  32  operand/result width; only 32 is verified
// PORTS
//   clk_i     in   1       single clock, rising edge
//   rst_i     in   1       reset, asynchronous, active-high
//   start_i   in   1       request; sampled only in IDLE
//   flush_i   in   1       synchronous abort (pipeline flush)
//   mdu_op_i  in   3       RV32M funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   a_i       in   DATA_W  rs1 (multiplicand / dividend)
//   b_i       in   DATA_W  rs2 (multiplier / divisor)
//   busy_o    out  1       high from the accepting edge until the edge that asserts valid_o
//   valid_o   out  1       one-cycle result pulse
//   result_o  out  DATA_W  result; held stable until the next accepted start
// BEHAVIOUR
//   - Reset (async, rst_i=1): state=IDLE, busy_o=0, valid_o=0, result_o=0, counter=0.
//   - States and transitions:
//     - IDLE: accept start_i (flush_i low) -> latch op, operand magnitudes and result sign.
//       Special case -> DONE; else -> CALC with counter=0.
//     - CALC: one step per cycle, counter 0..31.
//       Mul: shift-add on a 64-bit accumulator. Div: restoring shift-subtract.
//       At counter==31 -> DONE.
//     - DONE: register the sign-corrected result, valid_o=1 for exactly one cycle -> IDLE.
//   - Latency: an edge that accepts start_i gives valid_o high 33 cycles later (32 CALC + DONE).
//     Special cases give valid_o in the cycle right after acceptance.
//   - Signedness:
//     - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU/DIVU/REMU: unsigned.
//     - Magnitudes are taken at accept. The 64-bit product is negated when the signs differ.
//     - MUL returns product[31:0]; MULH* return product[63:32].
//     - DIV: quotient negated when the signs differ. REM: remainder takes the dividend's sign.
//   - Special cases (RISC-V spec):
//     - divide by zero: quotient=0xFFFFFFFF, remainder=a_i (signed and unsigned).
//     - signed overflow 0x80000000 / 0xFFFFFFFF: DIV=0x80000000, REM=0.
//   - Magnitude of 0x80000000 is 0x80000000 as unsigned 32 bits; no extra width is needed.
//   - start_i while busy: ignored, no queueing.
//     start_i and flush_i together in IDLE: flush wins, nothing accepted.
//   - flush_i in CALC or DONE: next state IDLE, valid_o forced 0 that cycle, result_o unchanged.
//   - Reset mid-operation: immediate IDLE, outputs to reset values, no valid_o afterwards.
//   - Operand inputs are don't-care after acceptance; the unit works only on latched copies.
//   - Back-to-back use: start_i may be accepted in the IDLE cycle right after DONE.
// STRUCTURE
//   - mdu_opcodes_pkg (sits beside alu_opcodes_pkg):
//     - MDU_MUL..MDU_REMU localparams (funct3 values).
//     - typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_t.
//     - MDU_STEPS = 32.
//   - Single module with no sub-module.
//     The shared 33-bit add/sub datapath serves both the mul add and the div trial subtract.
// TESTING
//   1. MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, valid_o exactly 33 cycles after start, busy_o high throughout.
//   2. MULH a=b=0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000;
//      MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
//   3. DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//   4. DIV/REM b=0, a=0x12345678 -> 0xFFFFFFFF / 0x12345678, valid_o one cycle after start;
//      DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
//   5. flush_i at counter 10 -> no valid_o, busy_o low next cycle, result_o unchanged;
//      start_i pulses while busy -> ignored.
//   6. rst_i asserted mid-CALC, off-edge -> outputs 0 immediately; next MUL 3*5 -> 15 with full 33-cycle latency.

Source files
------------

// File: rtl/mdu_opcodes_pkg.sv
// RV32M funct3 opcodes, FSM states and iteration count for the multiply/divide unit.
// Lives beside alu_opcodes_pkg so decode can share the encoding.
package mdu_opcodes_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    localparam int MDU_STEPS = 32;

    typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_t;

endpackage

// File: rtl/riscv_mdu.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract step
// per cycle on sign-stripped magnitudes, with sign correction and RISC-V special cases.
module riscv_mdu
    import mdu_opcodes_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [2:0]        mdu_op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int W     = DATA_W;
    localparam int CNT_W = $clog2(MDU_STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MDU_STEPS - 1);

    mdu_state_t       state_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     opnd_q;
    logic [2*W-1:0]   acc_q;
    logic             neg_q;
    logic             busy_q;
    logic             valid_q;
    logic [W-1:0]     result_q;

    // Accept-time decode: signedness, magnitudes, result sign and special cases.
    logic           a_signed, b_signed, a_neg, b_neg, is_rem_op;
    logic           div_zero, div_ovf, special, start_neg;
    logic [W-1:0]   a_mag, b_mag;
    logic [2*W-1:0] special_acc;

    always_comb begin
        a_signed    = mdu_op_i inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
        b_signed    = mdu_op_i inside {MDU_MULH, MDU_DIV, MDU_REM};
        a_neg       = a_signed & a_i[W-1];
        b_neg       = b_signed & b_i[W-1];
        a_mag       = a_neg ? -a_i : a_i;
        b_mag       = b_neg ? -b_i : b_i;
        is_rem_op   = mdu_op_i inside {MDU_REM, MDU_REMU};
        start_neg   = is_rem_op ? a_neg : (a_neg ^ b_neg);
        div_zero    = mdu_op_i[2] && (b_i == '0);
        div_ovf     = (mdu_op_i inside {MDU_DIV, MDU_REM})
                      && (a_i == {1'b1, {(W-1){1'b0}}}) && (b_i == '1);
        special     = div_zero | div_ovf;
        // acc holds {remainder, quotient}; these are the final, already sign-correct values.
        special_acc = div_zero ? {a_i, {W{1'b1}}}
                               : {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
    end

    // Shared 33-bit adder: multiply adds the multiplicand to the upper accumulator half,
    // divide trial-subtracts the divisor from {partial remainder, next dividend bit}.
    logic           is_div, no_borrow;
    logic [W:0]     add_x, add_y, mul_hi;
    logic [W+1:0]   add_res;
    logic [W-1:0]   rem_step;
    logic [2*W-1:0] acc_step;

    always_comb begin
        is_div    = op_q[2];
        add_x     = is_div ? acc_q[2*W-1:W-1] : {1'b0, acc_q[2*W-1:W]};
        add_y     = is_div ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
        add_res   = {1'b0, add_x} + {1'b0, add_y} + {{(W+1){1'b0}}, is_div};
        no_borrow = add_res[W+1];
        rem_step  = no_borrow ? add_res[W-1:0] : add_x[W-1:0];
        mul_hi    = acc_q[0] ? add_res[W:0] : add_x;
        acc_step  = is_div ? {rem_step, acc_q[W-2:0], no_borrow}
                           : {mul_hi, acc_q[W-1:1]};
    end

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   rem_fix, done_result;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        rem_fix  = neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        case (op_q)
            MDU_MUL, MDU_DIV, MDU_DIVU: done_result = prod_fix[W-1:0];
            MDU_REM, MDU_REMU:          done_result = rem_fix;
            default:                    done_result = prod_fix[2*W-1:W];
        endcase
    end

    // NOTE: all state below updates with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= MDU_MUL;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (start_i && !flush_i) begin
                        op_q   <= mdu_op_i;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (special) begin
                            acc_q   <= special_acc;
                            neg_q   <= 1'b0;
                            opnd_q  <= '0;
                            state_q <= DONE;
                        end else begin
                            acc_q   <= mdu_op_i[2] ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
                            opnd_q  <= mdu_op_i[2] ? b_mag : a_mag;
                            neg_q   <= start_neg;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_STEP) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (!flush_i) begin
                        result_q <= done_result;
                        valid_q  <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule
